// File: rtl/ll_pkg.sv
// ll_pkg: shared arbiter state encoding, default widths and requester indices
package ll_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} t_arb_states;
  localparam int DEF_NUM_REQ            = 3;
  localparam int DEF_DATAMEM_ADDR_WIDTH = 8;
  localparam int DEF_DATAMEM_WIDTH      = 32;
  localparam int DEF_NXTPTR_ADDR_WIDTH  = 8;
  localparam int DEF_NXTPTR_MEM_WIDTH   = 8;
  localparam int DEF_TIMEOUT_CYC        = 256;
  localparam int REQ_WR_CTRL      = 0;
  localparam int REQ_RD_WRBACK    = 1;
  localparam int REQ_FREE_RECLAIM = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ll_rr_pick.sv
// ll_rr_pick: first active requester at or after ptr, wrapping modulo N
module ll_rr_pick
  import ll_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  act,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);
  int j;
  always_comb begin
    pick = '0;
    idx  = '0;
    j    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (act[j]) begin
        pick    = '0;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ll_mem_wr_arb.sv
// ll_mem_wr_arb: round-robin owner of the data/nxtptr write ports; LL_MEM_WR_ARB_TIMEOUT_EN adds a BUSY watchdog
module ll_mem_wr_arb
  import ll_pkg::*;
#(
  parameter int NUM_REQ            = DEF_NUM_REQ,
  parameter int DATAMEM_ADDR_WIDTH = DEF_DATAMEM_ADDR_WIDTH,
  parameter int DATAMEM_WIDTH      = DEF_DATAMEM_WIDTH,
  parameter int NXTPTR_ADDR_WIDTH  = DEF_NXTPTR_ADDR_WIDTH,
  parameter int NXTPTR_MEM_WIDTH   = DEF_NXTPTR_MEM_WIDTH,
  parameter int TIMEOUT_CYC        = DEF_TIMEOUT_CYC
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQ-1:0]                     req_data_wr_vld,
  input  logic [NUM_REQ*DATAMEM_ADDR_WIDTH-1:0]  req_data_wr_addr,
  input  logic [NUM_REQ*DATAMEM_WIDTH-1:0]       req_data_wr_data,
  input  logic [NUM_REQ-1:0]                     req_nxtptr_wr_vld,
  input  logic [NUM_REQ*NXTPTR_ADDR_WIDTH-1:0]   req_nxtptr_wr_addr,
  input  logic [NUM_REQ*NXTPTR_MEM_WIDTH-1:0]    req_nxtptr_wr_data,
  output logic [NUM_REQ-1:0]                     req_data_wr_done,
  output logic [NUM_REQ-1:0]                     req_nxtptr_wr_done,
  output logic                                   data_mem_wr_vld,
  output logic [DATAMEM_ADDR_WIDTH-1:0]          data_mem_wr_addr,
  output logic [DATAMEM_WIDTH-1:0]               data_mem_wr_data,
  input  logic                                   data_mem_wr_done,
  output logic                                   nxtptr_mem_wr_vld,
  output logic [NXTPTR_ADDR_WIDTH-1:0]           nxtptr_mem_wr_addr,
  output logic [NXTPTR_MEM_WIDTH-1:0]            nxtptr_mem_wr_data,
  input  logic                                   nxtptr_mem_wr_done,
  output logic [NUM_REQ-1:0]                     arb_grant,
  output logic                                   arb_busy,
  output logic                                   arb_timeout_err
);
  localparam int IW = idx_w(NUM_REQ);
  t_arb_states state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, act, pick;
  logic [IW-1:0] gidx_q, gidx_d, ptr_q, ptr_d, pick_idx;
  logic pend_data_q, pend_data_d, pend_ptr_q, pend_ptr_d;
  logic dprev_q, dprev_d, pprev_q, pprev_d;
  logic busy, d_vld, p_vld;
  assign act   = req_data_wr_vld | req_nxtptr_wr_vld;
  assign busy  = state_q == BUSY;
  assign d_vld = req_data_wr_vld[gidx_q];
  assign p_vld = req_nxtptr_wr_vld[gidx_q];
  ll_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .act  (act),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
  localparam int CW = idx_w(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout;
  assign arb_timeout_err = timeout;
`else
  assign arb_timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      pend_data_q <= 1'b0;
      pend_ptr_q  <= 1'b0;
      dprev_q     <= 1'b0;
      pprev_q     <= 1'b0;
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      pend_data_q <= pend_data_d;
      pend_ptr_q  <= pend_ptr_d;
      dprev_q     <= dprev_d;
      pprev_q     <= pprev_d;
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  // dprev/pprev track the granted vlds so only a fresh rise re-arms a pending bit
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    pend_data_d = pend_data_q;
    pend_ptr_d  = pend_ptr_q;
    dprev_d     = d_vld;
    pprev_d     = p_vld;
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
    cnt_d       = cnt_q + 1'b1;
    timeout     = 1'b0;
`endif
    case (state_q)
      IDLE: if (|act) begin
        state_d     = BUSY;
        grant_d     = pick;
        gidx_d      = pick_idx;
        pend_data_d = req_data_wr_vld[pick_idx];
        pend_ptr_d  = req_nxtptr_wr_vld[pick_idx];
        dprev_d     = req_data_wr_vld[pick_idx];
        pprev_d     = req_nxtptr_wr_vld[pick_idx];
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      BUSY: begin
        pend_data_d = (pend_data_q | (d_vld & ~dprev_q)) & ~data_mem_wr_done;
        pend_ptr_d  = (pend_ptr_q | (p_vld & ~pprev_q)) & ~nxtptr_mem_wr_done;
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
        timeout     = cnt_q == CW'(TIMEOUT_CYC - 1) && (pend_data_d || pend_ptr_d);
        pend_data_d = pend_data_d & ~timeout;
        pend_ptr_d  = pend_ptr_d & ~timeout;
`endif
        if (!pend_data_d && !pend_ptr_d) begin
          state_d = GAP;
          grant_d = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
        ptr_d   = gidx_q == IW'(NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    arb_grant          = grant_q;
    arb_busy           = busy;
    data_mem_wr_vld    = busy & d_vld;
    data_mem_wr_addr   = data_mem_wr_vld ? req_data_wr_addr[gidx_q*DATAMEM_ADDR_WIDTH +: DATAMEM_ADDR_WIDTH] : '0;
    data_mem_wr_data   = data_mem_wr_vld ? req_data_wr_data[gidx_q*DATAMEM_WIDTH +: DATAMEM_WIDTH] : '0;
    nxtptr_mem_wr_vld  = busy & p_vld;
    nxtptr_mem_wr_addr = nxtptr_mem_wr_vld ? req_nxtptr_wr_addr[gidx_q*NXTPTR_ADDR_WIDTH +: NXTPTR_ADDR_WIDTH] : '0;
    nxtptr_mem_wr_data = nxtptr_mem_wr_vld ? req_nxtptr_wr_data[gidx_q*NXTPTR_MEM_WIDTH +: NXTPTR_MEM_WIDTH] : '0;
    req_data_wr_done   = (busy & data_mem_wr_done) ? grant_q : '0;
    req_nxtptr_wr_done = (busy & nxtptr_mem_wr_done) ? grant_q : '0;
  end
endmodule

// File: tb/tb_ll_mem_wr_arb.sv
// tb_ll_mem_wr_arb: requester/memory models feed a scoreboard monitor that checks grants, forwarding and writes
module tb_ll_mem_wr_arb;
  localparam int N = 3, AW = 8, DW = 32, PAW = 8, PW = 8, TO = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_data_wr_vld = '0, req_nxtptr_wr_vld = '0;
  logic [N*AW-1:0] req_data_wr_addr = '0;
  logic [N*DW-1:0] req_data_wr_data = '0;
  logic [N*PAW-1:0] req_nxtptr_wr_addr = '0;
  logic [N*PW-1:0] req_nxtptr_wr_data = '0;
  logic [N-1:0] req_data_wr_done, req_nxtptr_wr_done, arb_grant;
  logic data_mem_wr_vld, nxtptr_mem_wr_vld, arb_busy, arb_timeout_err;
  logic data_mem_wr_done = 1'b0, nxtptr_mem_wr_done = 1'b0;
  logic [AW-1:0] data_mem_wr_addr;
  logic [DW-1:0] data_mem_wr_data;
  logic [PAW-1:0] nxtptr_mem_wr_addr;
  logic [PW-1:0] nxtptr_mem_wr_data;
  always #5 clk = ~clk;
  ll_mem_wr_arb #(.NUM_REQ(N), .DATAMEM_ADDR_WIDTH(AW), .DATAMEM_WIDTH(DW),
    .NXTPTR_ADDR_WIDTH(PAW), .NXTPTR_MEM_WIDTH(PW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_data_wr_vld(req_data_wr_vld), .req_data_wr_addr(req_data_wr_addr), .req_data_wr_data(req_data_wr_data),
    .req_nxtptr_wr_vld(req_nxtptr_wr_vld), .req_nxtptr_wr_addr(req_nxtptr_wr_addr), .req_nxtptr_wr_data(req_nxtptr_wr_data),
    .req_data_wr_done(req_data_wr_done), .req_nxtptr_wr_done(req_nxtptr_wr_done),
    .data_mem_wr_vld(data_mem_wr_vld), .data_mem_wr_addr(data_mem_wr_addr), .data_mem_wr_data(data_mem_wr_data),
    .data_mem_wr_done(data_mem_wr_done),
    .nxtptr_mem_wr_vld(nxtptr_mem_wr_vld), .nxtptr_mem_wr_addr(nxtptr_mem_wr_addr), .nxtptr_mem_wr_data(nxtptr_mem_wr_data),
    .nxtptr_mem_wr_done(nxtptr_mem_wr_done),
    .arb_grant(arb_grant), .arb_busy(arb_busy), .arb_timeout_err(arb_timeout_err)
  );
  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction
  function automatic int rr_first(input logic [N-1:0] a, input int p);
    for (int k = 0; k < N; k++) if (a[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // scoreboard: expected writes per requester, plus requester/memory model state
  logic [63:0] exp_d [N][$];
  logic [63:0] exp_p [N][$];
  bit iss_d [N], iss_p [N], got_d [N], got_p [N], got_to [N], persist [N];
  bit rand_en = 0, m_hold = 0, mon_en = 0, d_seen = 0, p_seen = 0;
  bit m_out [2];
  int m_dly [2];
  int m_fix [2] = '{-1, -1};
  int owner = -1, mptr = 0, idle_n = 99, own_cyc = 0, busy_cyc = 0, to_cnt = 0, w;
  bit od, op, exp_to;
  logic [N-1:0] prev_act = '0;
  int glog[$];
  task automatic issue(input int i, input bit hd, input bit hp, input logic [7:0] da, input logic [31:0] dd,
                       input logic [7:0] pa, input logic [7:0] pd);
    iss_d[i] = hd;
    iss_p[i] = hp;
    req_data_wr_vld[i] = hd;
    req_nxtptr_wr_vld[i] = hp;
    req_data_wr_addr[i*AW +: AW] = da;
    req_data_wr_data[i*DW +: DW] = dd;
    req_nxtptr_wr_addr[i*PAW +: PAW] = pa;
    req_nxtptr_wr_data[i*PW +: PW] = pd;
    if (hd) exp_d[i].push_back({24'h0, da, dd});
    if (hp) exp_p[i].push_back({48'h0, pa, pd});
  endtask
  task automatic rand_issue(input int i);
    bit hd, hp;
    hd = 1'($urandom_range(0, 1));
    hp = hd ? 1'($urandom_range(0, 1)) : 1'b1;
    issue(i, hd, hp, 8'($urandom), $urandom, 8'($urandom), 8'($urandom));
  endtask
  task automatic step();
    @(negedge clk);
    if (data_mem_wr_vld && !m_out[0] && !m_hold) begin
      m_out[0] = 1;
      m_dly[0] = m_fix[0] >= 0 ? m_fix[0] : $urandom_range(0, 4);
    end
    if (nxtptr_mem_wr_vld && !m_out[1] && !m_hold) begin
      m_out[1] = 1;
      m_dly[1] = m_fix[1] >= 0 ? m_fix[1] : $urandom_range(0, 4);
    end
    @(posedge clk);
    #1;
    if (data_mem_wr_done) begin data_mem_wr_done = 0; m_out[0] = 0; end
    if (nxtptr_mem_wr_done) begin nxtptr_mem_wr_done = 0; m_out[1] = 0; end
    for (int i = 0; i < N; i++) begin
      if (got_d[i]) begin req_data_wr_vld[i] = 0; got_d[i] = 0; end
      if (got_p[i]) begin req_nxtptr_wr_vld[i] = 0; got_p[i] = 0; end
      if (got_to[i]) begin req_data_wr_vld[i] = 0; req_nxtptr_wr_vld[i] = 0; got_to[i] = 0; end
    end
    if (m_out[0]) begin if (m_dly[0] == 0) data_mem_wr_done = 1; else m_dly[0]--; end
    if (m_out[1]) begin if (m_dly[1] == 0) nxtptr_mem_wr_done = 1; else m_dly[1]--; end
    for (int i = 0; i < N; i++)
      if (!req_data_wr_vld[i] && !req_nxtptr_wr_vld[i] && (persist[i] || (rand_en && $urandom_range(0, 3) == 0)))
        rand_issue(i);
  endtask
  function automatic bit quiet();
    return owner < 0 && idle_n >= 2 && (req_data_wr_vld | req_nxtptr_wr_vld) == '0;
  endfunction
  task automatic quiesce();
    for (int k = 0; k < 300 && !quiet(); k++) step();
    chk("quiesce", quiet(), 1);
  endtask
  // monitor: reference model of ownership derived from the rotation rule and request history
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req_data_wr_done[i]) got_d[i] = 1;
      if (req_nxtptr_wr_done[i]) got_p[i] = 1;
      if (arb_timeout_err && arb_grant[i]) got_to[i] = 1;
    end
    if (mon_en) begin
      if (arb_busy) busy_cyc++;
      if (arb_timeout_err) to_cnt++;
      if (owner < 0) begin
        if (idle_n >= 2 && prev_act != '0) begin
          w = rr_first(prev_act, mptr);
          chk("grant", arb_grant, oh(w));
          owner = w;
          mptr = (w + 1) % N;
          own_cyc = 0;
          od = iss_d[w];
          op = iss_p[w];
          glog.push_back(w);
        end else begin
          chk("idle_grant", arb_grant, 0);
          idle_n++;
        end
      end
      if (owner >= 0) begin
        own_cyc++;
        chk("hold_grant", arb_grant, oh(owner));
        chk("busy", arb_busy, 1);
        chk("d_done_fwd", req_data_wr_done, data_mem_wr_done ? oh(owner) : '0);
        chk("p_done_fwd", req_nxtptr_wr_done, nxtptr_mem_wr_done ? oh(owner) : '0);
        chk("d_mem_vld", data_mem_wr_vld, req_data_wr_vld[owner]);
        chk("p_mem_vld", nxtptr_mem_wr_vld, req_nxtptr_wr_vld[owner]);
        if (data_mem_wr_vld && !d_seen) begin
          d_seen = 1;
          if (exp_d[owner].size() == 0) chk("d_unexpected", 1, 0);
          else chk("d_write", {24'h0, data_mem_wr_addr, data_mem_wr_data}, exp_d[owner].pop_front());
        end
        if (!data_mem_wr_vld) chk("d_zero", {data_mem_wr_addr, data_mem_wr_data}, 0);
        if (nxtptr_mem_wr_vld && !p_seen) begin
          p_seen = 1;
          if (exp_p[owner].size() == 0) chk("p_unexpected", 1, 0);
          else chk("p_write", {48'h0, nxtptr_mem_wr_addr, nxtptr_mem_wr_data}, exp_p[owner].pop_front());
        end
        if (!nxtptr_mem_wr_vld) chk("p_zero", {nxtptr_mem_wr_addr, nxtptr_mem_wr_data}, 0);
        if (data_mem_wr_done) begin od = 0; d_seen = 0; end
        if (nxtptr_mem_wr_done) begin op = 0; p_seen = 0; end
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
        exp_to = own_cyc == TO && (od || op);
`else
        exp_to = 0;
`endif
        chk("timeout_err", arb_timeout_err, exp_to);
        if (exp_to || (!od && !op)) begin
          owner = -1;
          idle_n = 0;
          d_seen = 0;
          p_seen = 0;
        end
      end else begin
        chk("idle_out", {arb_busy, arb_timeout_err, data_mem_wr_vld, nxtptr_mem_wr_vld, req_data_wr_done,
                         req_nxtptr_wr_done, data_mem_wr_addr, data_mem_wr_data}, 0);
        chk("idle_ptr", {nxtptr_mem_wr_addr, nxtptr_mem_wr_data}, 0);
      end
    end
    prev_act = req_data_wr_vld | req_nxtptr_wr_vld;
  end
  int exp3[4] = '{0, 1, 2, 0};
  int sb_left;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    mon_en = 1;
    @(negedge clk);
    chk("reset_state", {arb_grant, arb_busy, arb_timeout_err, data_mem_wr_vld, nxtptr_mem_wr_vld}, 0);
    @(posedge clk);
    #1;
    // contention from reset: rotation 0,1,2,0
    for (int i = 0; i < N; i++) persist[i] = 1;
    for (int k = 0; k < 300 && glog.size() < 4; k++) step();
    for (int i = 0; i < N; i++) persist[i] = 0;
    chk("order_len", glog.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk("order", glog[k], exp3[k]);
    quiesce();
    // single request, both dones in the same cycle
    m_fix = '{0, 0};
    busy_cyc = 0;
    glog.delete();
    issue(0, 1, 1, 8'h05, 32'hDEADBEEF, 8'h06, 8'h5A);
    quiesce();
    chk("single_who", glog.size() == 1 && glog[0] == 0, 1);
    chk("single_busy", busy_cyc, 2);
    // split done: data at busy cycle 3, nxtptr at busy cycle 7
    m_fix = '{1, 5};
    busy_cyc = 0;
    issue(1, 1, 1, 8'h11, 32'h12345678, 8'h22, 8'h33);
    quiesce();
    chk("split_busy", busy_cyc, 7);
    // pointer wrap: pointer now 2, req0 and req1 both active -> req0 first
    m_fix = '{-1, -1};
    glog.delete();
    issue(0, 1, 0, 8'hA0, 32'hA0A0A0A0, 8'h0, 8'h0);
    issue(1, 0, 1, 8'h0, 32'h0, 8'hB1, 8'hB2);
    quiesce();
    chk("wrap_len", glog.size(), 2);
    chk("wrap_first", glog.size() == 2 && glog[0] == 0 && glog[1] == 1, 1);
    // stray done in IDLE must be ignored
    data_mem_wr_done = 1;
    nxtptr_mem_wr_done = 1;
    step();
    glog.delete();
    issue(2, 1, 1, 8'hC0, 32'hC0FFEE00, 8'hC1, 8'hC2);
    quiesce();
    chk("stray_then_grant", glog.size() == 1 && glog[0] == 2, 1);
`ifdef LL_MEM_WR_ARB_TIMEOUT_EN
    m_hold = 1;
    to_cnt = 0;
    issue(2, 1, 0, 8'hE0, 32'hE0E0E0E0, 8'h0, 8'h0);
    for (int k = 0; k < 30; k++) step();
    m_hold = 0;
    chk("timeout_pulses", to_cnt, 1);
    glog.delete();
    issue(0, 1, 1, 8'hF0, 32'hF0F0F0F0, 8'hF1, 8'hF2);
    quiesce();
    chk("after_timeout", glog.size() == 1 && glog[0] == 0, 1);
`endif
    // randomized traffic
    rand_en = 1;
    for (int k = 0; k < 3000; k++) step();
    rand_en = 0;
    quiesce();
    sb_left = 0;
    for (int i = 0; i < N; i++) sb_left += exp_d[i].size() + exp_p[i].size();
    chk("sb_empty", sb_left, 0);
    // reset in the middle of BUSY drops the grant and forwards nothing
    mon_en = 0;
    m_hold = 1;
    issue(1, 1, 0, 8'h77, 32'h77777777, 8'h0, 8'h0);
    for (int k = 0; k < 6 && arb_grant == '0; k++) step();
    chk("rst_pre_grant", arb_grant, 3'b010);
    reset_n = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    data_mem_wr_done = 1;
    @(negedge clk);
    chk("rst_grant", arb_grant, 0);
    chk("rst_out", {arb_busy, req_data_wr_done, req_nxtptr_wr_done, data_mem_wr_vld}, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/ll_mem_wr_arb.md
Name: ll_mem_wr_arb

Overview:
Round-robin arbiter sharing the single write port of the data memory and the nxtptr memory among NUM_REQ linked-list write requesters.
- Typical requesters: index 0 write controller, 1 read-controller writeback, 2 free-list reclaim.
- Grants one requester at a time and holds the grant until every write it issued has completed.
- Forwards memory done pulses back only to the granted requester.
- Sits between the requesters and the data/nxtptr memory write interfaces.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATAMEM_ADDR_WIDTH, 8, data memory address width
DATAMEM_WIDTH, 32, data memory word width
NXTPTR_ADDR_WIDTH, 8, nxtptr memory address width
NXTPTR_MEM_WIDTH, 8, nxtptr memory word width
TIMEOUT_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_data_wr_vld  in  NUM_REQ  per-requester data-mem write request
req_data_wr_addr  in  NUM_REQ*DATAMEM_ADDR_WIDTH  flattened addresses; requester i in slice i
req_data_wr_data  in  NUM_REQ*DATAMEM_WIDTH  flattened write data
req_nxtptr_wr_vld  in  NUM_REQ  per-requester nxtptr-mem write request
req_nxtptr_wr_addr  in  NUM_REQ*NXTPTR_ADDR_WIDTH  flattened addresses
req_nxtptr_wr_data  in  NUM_REQ*NXTPTR_MEM_WIDTH  flattened write data
req_data_wr_done  out  NUM_REQ  forwarded data-mem done
req_nxtptr_wr_done  out  NUM_REQ  forwarded nxtptr-mem done
data_mem_wr_vld/addr/data  out  1/DATAMEM_ADDR_WIDTH/DATAMEM_WIDTH  to data memory
data_mem_wr_done  in  1  data memory done pulse
nxtptr_mem_wr_vld/addr/data  out  1/NXTPTR_ADDR_WIDTH/NXTPTR_MEM_WIDTH  to nxtptr memory
nxtptr_mem_wr_done  in  1  nxtptr memory done pulse
arb_grant  out  NUM_REQ  one-hot current grant; 0 when not BUSY
arb_busy  out  1  high in BUSY
arb_timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state IDLE, grant 0, pending bits 0, round-robin pointer 0.
  - All outputs read 0 from the first cycle after the reset edge.
  - Reset mid-transaction drops the grant without forwarding any done.
- A requester is active when its data_vld OR nxtptr_vld is high.
- A requester must hold its vld/addr/data stable until it receives the matching done.
- FSM:
  - IDLE: if any requester is active, pick the first active index at or after the pointer (wrapping modulo NUM_REQ). Register the one-hot grant. Set pend_data and pend_ptr from that requester's vlds. Go to BUSY. No grant is issued in the same cycle a request first appears.
  - BUSY:
    - data_mem_wr_vld/addr/data = granted requester's data signals gated by its data_vld; nxtptr port likewise. All mux outputs are 0 otherwise.
    - data_mem_wr_done is forwarded combinationally to req_data_wr_done[grant] and clears pend_data. nxtptr done is handled the same way with pend_ptr.
    - A vld rising during BUSY on a port whose pending bit is clear sets that bit (sticky).
    - When both pending bits are clear at a clock edge, go to GAP.
    - If both dones arrive in the same cycle, both are forwarded and both bits clear together.
  - GAP: one cycle with no grant, so the requester can drop its vld. Pointer becomes (granted index + 1) mod NUM_REQ. Go to IDLE.
- Done inputs arriving outside BUSY are ignored and not forwarded.
- Latency: request to memory vld is 1 cycle. Back-to-back grants are separated by at least 2 idle-port cycles (GAP + IDLE).
- Simultaneous requests are served in rotating order from the pointer. No requester waits more than NUM_REQ-1 other grants.
- Grant index is stored in $clog2(NUM_REQ) bits. Pointer wrap compares against NUM_REQ-1.

Optional Feature:
Macro LL_MEM_WR_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - At count TIMEOUT_CYC-1 with pending bits still set: pulse arb_timeout_err, clear pending bits, go to GAP. No done is forwarded for the aborted writes.
  - The pointer advances as normal.
- Undefined: no counter exists, arb_timeout_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- ll_pkg holds the state enum t_arb_states {IDLE, BUSY, GAP}, the default width localparams, and the requester index constants (REQ_WR_CTRL=0, REQ_RD_WRBACK=1, REQ_FREE_RECLAIM=2).
- Sub-module ll_rr_pick: combinational, inputs active mask and pointer, outputs one-hot pick and index.

Test Plan:
1. Single request: req0 data+nxtptr vld (addr 0x05, data 0xDEADBEEF, ptr 0x06). Memory vlds rise 1 cycle later with those values. Both dones in the same cycle go to req0 only. GAP, then IDLE.
2. Split done: req1 issues both writes. Data done comes at cycle 3, nxtptr done at cycle 7. Grant is held until cycle 7. Each done is forwarded once.
3. Contention: req0, req1, req2 held active continuously from reset. Grant order is 0, 1, 2, 0. Each grant is separated by GAP+IDLE.
4. Pointer wrap: pointer=2 with req0 and req1 active. Req0 is granted next.
5. Stray done: data_mem_wr_done pulses in IDLE. No req_data_wr_done is asserted and the state is unchanged.
6. With LL_MEM_WR_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: req2 gets no done. arb_timeout_err pulses in the 16th BUSY cycle, then GAP, then req0 can be granted. Reset asserted mid-BUSY gives arb_grant=0 the next cycle.
